// File: rtl/dp_seq_pkg.sv
// rtl/dp_seq_pkg.sv - shared types and constants for the datapath sequencer
// Step encoding, instruction classes, INSTR field positions and the control bundle.
package dp_seq_pkg;
  localparam int DATA_W = 10;
  localparam int RA_W   = 2;
  localparam int FN_W   = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

  localparam logic [1:0] CL_LD  = 2'b00;
  localparam logic [1:0] CL_MOV = 2'b01;
  localparam logic [1:0] CL_ALU = 2'b10;
  localparam logic [1:0] CL_IMM = 2'b11;

  localparam int CLS_HI = 9;
  localparam int CLS_LO = 8;
  localparam int FN_HI  = 7;
  localparam int FN_LO  = 4;
  localparam int RX_HI  = 3;
  localparam int RX_LO  = 2;
  localparam int RY_HI  = 1;
  localparam int RY_LO  = 0;

  typedef struct packed {
    logic            ext;
    logic            irin;
    logic            enw;
    logic [RA_W-1:0] wra;
    logic            enr;
    logic [RA_W-1:0] rda;
    logic            ain;
    logic            gin;
    logic            gout;
    logic [FN_W-1:0] alucont;
    logic            done;
  } ctrl_t;
endpackage

// File: rtl/dp_seq_if.sv
// rtl/dp_seq_if.sv - sequencer-to-datapath control bundle
// master is the sequencer side, slave is the datapath/stimulus side.
interface dp_seq_if;
  import dp_seq_pkg::*;

  logic              STEP;
  logic [DATA_W-1:0] INSTR;
  logic              Ext;
  logic              IRin;
  logic              ENW;
  logic [RA_W-1:0]   WRA;
  logic              ENR;
  logic [RA_W-1:0]   RDA;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic [FN_W-1:0]   ALUcont;
  logic              Done;
  logic [1:0]        T;
  logic              BUSY;
  logic [CNT_W-1:0]  ICNT;

  modport master (
    input  STEP, INSTR,
    output Ext, IRin, ENW, WRA, ENR, RDA, Ain, Gin, Gout, ALUcont, Done, T, BUSY, ICNT
  );

  modport slave (
    output STEP, INSTR,
    input  Ext, IRin, ENW, WRA, ENR, RDA, Ain, Gin, Gout, ALUcont, Done, T, BUSY, ICNT
  );
endinterface

// File: rtl/dp_seq_decode.sv
// rtl/dp_seq_decode.sv - combinational step/instruction decode to control bundle
// SEQ_IMM_EN: class 11 becomes ALU-immediate; otherwise class 11 is a one-step NOP.
module dp_seq_decode
  import dp_seq_pkg::*;
(
  input  step_t             state,
  input  logic [DATA_W-1:0] instr,
  input  logic              step,
  output ctrl_t             ctrl
);
  logic [1:0]      cls;
  logic [FN_W-1:0] fn;
  logic [RA_W-1:0] rx;
  logic [RA_W-1:0] ry;

  assign cls = instr[CLS_HI:CLS_LO];
  assign fn  = instr[FN_HI:FN_LO];
  assign rx  = instr[RX_HI:RX_LO];
  assign ry  = instr[RY_HI:RY_LO];

  // Write/load strobes are qualified by step; bus drivers stay level so the bus is stable.
  always_comb begin
    ctrl = '0;
    case (state)
      T0: begin
        ctrl.ext  = 1'b1;
        ctrl.irin = step;
      end
      T1: begin
        case (cls)
          CL_LD: begin
            ctrl.ext  = 1'b1;
            ctrl.enw  = step;
            ctrl.wra  = rx;
            ctrl.done = 1'b1;
          end
          CL_MOV: begin
            ctrl.enr  = 1'b1;
            ctrl.rda  = ry;
            ctrl.enw  = step;
            ctrl.wra  = rx;
            ctrl.done = 1'b1;
          end
          CL_ALU: begin
            ctrl.enr = 1'b1;
            ctrl.rda = rx;
            ctrl.ain = step;
          end
          default: begin
`ifdef SEQ_IMM_EN
            ctrl.enr = 1'b1;
            ctrl.rda = rx;
            ctrl.ain = step;
`else
            ctrl.done = 1'b1;
`endif
          end
        endcase
      end
      T2: begin
        if (cls == CL_ALU) begin
          ctrl.enr     = 1'b1;
          ctrl.rda     = ry;
          ctrl.gin     = step;
          ctrl.alucont = fn;
        end
`ifdef SEQ_IMM_EN
        else if (cls == CL_IMM) begin
          ctrl.ext     = 1'b1;
          ctrl.gin     = step;
          ctrl.alucont = fn;
        end
`endif
      end
      T3: begin
`ifdef SEQ_IMM_EN
        if (cls == CL_ALU || cls == CL_IMM) begin
`else
        if (cls == CL_ALU) begin
`endif
          ctrl.gout = 1'b1;
          ctrl.enw  = step;
          ctrl.wra  = rx;
          ctrl.done = 1'b1;
        end
      end
    endcase
  end
endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - T-step sequencer for the 10-bit shared-bus datapath
// Holds the step register and retired-instruction counter; decode is in dp_seq_decode.
module datapath_sequencer
  import dp_seq_pkg::*;
(
  input  logic     CLK,
  input  logic     CLR,
  dp_seq_if.master bus
);
  step_t            state;
  logic [CNT_W-1:0] icnt;
  ctrl_t            ctrl;

  dp_seq_decode u_decode (
    .state (state),
    .instr (bus.INSTR),
    .step  (bus.STEP),
    .ctrl  (ctrl)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= T0;
      icnt  <= '0;
    end else if (bus.STEP) begin
      if (ctrl.done) begin
        state <= T0;
        icnt  <= icnt + CNT_W'(1);
      end else begin
        state <= step_t'(state + 2'd1);
      end
    end
  end

  assign bus.Ext     = ctrl.ext;
  assign bus.IRin    = ctrl.irin;
  assign bus.ENW     = ctrl.enw;
  assign bus.WRA     = ctrl.wra;
  assign bus.ENR     = ctrl.enr;
  assign bus.RDA     = ctrl.rda;
  assign bus.Ain     = ctrl.ain;
  assign bus.Gin     = ctrl.gin;
  assign bus.Gout    = ctrl.gout;
  assign bus.ALUcont = ctrl.alucont;
  assign bus.Done    = ctrl.done;
  assign bus.T       = state;
  assign bus.BUSY    = (state != T0);
  assign bus.ICNT    = icnt;
endmodule
